// File: rtl/ic555_pkg.sv
// Shared types for the 555 astable sequencer.
//   state_e     : sequencer states (S_ prefix keeps them clear of the RST_HOLD parameter)
//   CNT_W_DEF   : default phase-counter / measurement width
//   meas_pair_t : one completed period (charge length, discharge length)
package ic555_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_CHARGE,
    S_DISCHARGE,
    S_FAULT
  } state_e;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] hi;
    logic [CNT_W_DEF-1:0] lo;
  } meas_pair_t;

endpackage

// File: rtl/ic555_phase_cnt.sv
// Saturating phase counter with clear, enable and timeout flag.
//   clk, rst : clock, async active-high reset
//   clr_i    : restart; together with en_i the counter reads 1 in the next
//              cycle (the first cycle of a new phase), alone it loads 0
//   en_i     : count one cycle, saturating at all-ones
//   cnt_o    : current count
//   tmo_o    : count has reached TIMEOUT
module ic555_phase_cnt #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tmo_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = en_i ? ONE : '0;
    else if (en_i && ~&cnt_q)  cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tmo_o = (cnt_q >= TMO);

endmodule

// File: rtl/ic555_astable_ctrl.sv
// Digital sequencer for a 555 astable stage.
// Reads the trigger (< vcc/3) and threshold (> 2vcc/3) comparators, drives the
// 555 reset pin and discharge switch, measures charge/discharge phase lengths
// in clk cycles and offers each completed period on a valid/ready port.
// Ports:
//   clk, rst               : clock, async active-high reset
//   en                     : run request (0 forces IDLE)
//   cmp_trig, cmp_thresh   : comparator decisions
//   ic_rst_n, dis_en, out_q: 555 pin4, pin7 switch, charge-phase indicator
//   meas_valid/meas_ready  : measurement handshake
//   meas_hi, meas_lo       : charge / discharge lengths of the offered pair
//   meas_ovr               : sticky, a pair was dropped
//   fault                  : sticky while faulted, phase timeout
// Build option: define ASTABLE_SYNC_EN to pass both comparators through a
// 2-flop synchronizer (adds 2 cycles latency, phase lengths unchanged).
module ic555_astable_ctrl
  import ic555_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RST_HOLD = 4,
  parameter int TIMEOUT  = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmp_trig,
  input  logic             cmp_thresh,
  output logic             ic_rst_n,
  output logic             dis_en,
  output logic             out_q,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_hi,
  output logic [CNT_W-1:0] meas_lo,
  output logic             meas_ovr,
  output logic             fault
);

  logic trig, thresh;

`ifdef ASTABLE_SYNC_EN
  logic [1:0] trig_sync_q, thresh_sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_sync_q   <= '0;
      thresh_sync_q <= '0;
    end else begin
      trig_sync_q   <= {trig_sync_q[0], cmp_trig};
      thresh_sync_q <= {thresh_sync_q[0], cmp_thresh};
    end
  end
  assign trig   = trig_sync_q[1];
  assign thresh = thresh_sync_q[1];
`else
  assign trig   = cmp_trig;
  assign thresh = cmp_thresh;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             tmo;
  logic             cnt_clr, cnt_en;
  logic             chg_exit, dis_exit, pair_new, xfer;

  logic [CNT_W-1:0] hi_tmp_q, hi_tmp_d;
  logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             fault_q, fault_d;
  logic             primed_q, primed_d;

  // The same counter times RST_HOLD and both oscillator phases; any state
  // change restarts it so the first cycle of a phase reads 1.
  ic555_phase_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tmo_o (tmo)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (en) state_d = S_RST_HOLD;
      S_RST_HOLD:  if (cnt == CNT_W'(RST_HOLD)) state_d = S_CHARGE;
      // exit condition is checked first so it wins over a coincident timeout
      S_CHARGE:    if (thresh) state_d = S_DISCHARGE;
                   else if (tmo) state_d = S_FAULT;
      S_DISCHARGE: if (trig) state_d = S_CHARGE;
                   else if (tmo) state_d = S_FAULT;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_IDLE;
    endcase
    if (!en) state_d = S_IDLE;
  end

  assign cnt_clr  = (state_d != state_q);
  assign cnt_en   = (state_d == S_RST_HOLD) || (state_d == S_CHARGE) ||
                    (state_d == S_DISCHARGE);
  assign chg_exit = (state_q == S_CHARGE)    && (state_d == S_DISCHARGE);
  assign dis_exit = (state_q == S_DISCHARGE) && (state_d == S_CHARGE);
  // first period after IDLE starts from 0 V, so it is never emitted
  assign pair_new = dis_exit && primed_q;
  assign xfer     = valid_q && meas_ready;

  always_comb begin
    hi_tmp_d = chg_exit ? cnt : hi_tmp_q;
    primed_d = (state_q == S_IDLE) ? 1'b0 : (dis_exit ? 1'b1 : primed_q);
    hi_d     = hi_q;
    lo_d     = lo_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (pair_new) begin
      // a pair landing on a transfer cycle replaces the one leaving
      if (!valid_q || xfer) begin
        hi_d    = hi_tmp_q;
        lo_d    = cnt;
        valid_d = 1'b1;
      end else begin
        ovr_d   = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    fault_d = fault_q;
    if (state_d == S_FAULT)     fault_d = 1'b1;
    else if (state_d == S_IDLE) fault_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hi_tmp_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      fault_q  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_tmp_q <= hi_tmp_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
      fault_q  <= fault_d;
      primed_q <= primed_d;
    end
  end

  always_comb begin
    ic_rst_n = 1'b0;
    dis_en   = 1'b1;
    out_q    = 1'b0;
    unique case (state_q)
      S_CHARGE: begin
        ic_rst_n = 1'b1;
        dis_en   = 1'b0;
        out_q    = 1'b1;
      end
      S_DISCHARGE: ic_rst_n = 1'b1;
      default: ;
    endcase
  end

  assign meas_valid = valid_q;
  assign meas_hi    = hi_q;
  assign meas_lo    = lo_q;
  assign meas_ovr   = ovr_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_ic555_astable_ctrl.sv
// Directed bench for ic555_astable_ctrl (RST_HOLD=4, TIMEOUT=100).
// Inputs are driven 2 time units after each rising edge; outputs are sampled
// there or on the falling edge. Expected pairs are queued when the DUT is
// told to finish a period and popped when a transfer is seen.
module tb_ic555_astable_ctrl;
  import ic555_pkg::*;

  localparam int CNT_W = 16;

  logic             clk, rst, en, cmp_trig, cmp_thresh, meas_ready;
  logic             ic_rst_n, dis_en, out_q, meas_valid, meas_ovr, fault;
  logic [CNT_W-1:0] meas_hi, meas_lo;

  int n_chk  = 0;
  int n_fail = 0;
  meas_pair_t exp_q[$];

  ic555_astable_ctrl #(.CNT_W(CNT_W), .RST_HOLD(4), .TIMEOUT(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cmp_trig   (cmp_trig),
    .cmp_thresh (cmp_thresh),
    .ic_rst_n   (ic_rst_n),
    .dis_en     (dis_en),
    .out_q      (out_q),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_hi    (meas_hi),
    .meas_lo    (meas_lo),
    .meas_ovr   (meas_ovr),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // called in CHARGE cycle `done`; leaves the DUT in DISCHARGE cycle 1
  task automatic charge_phase(input int hi, input int done);
    repeat (hi - done) step();
    cmp_thresh = 1'b1;
    step();
    cmp_thresh = 1'b0;
  endtask

  // called in DISCHARGE cycle 1; leaves the DUT in CHARGE cycle 1
  task automatic dis_phase(input int hi, input int lo, input bit push);
    meas_pair_t p;
    repeat (lo - 1) step();
    cmp_trig = 1'b1;
    if (push) begin
      p.hi = CNT_W'(hi);
      p.lo = CNT_W'(lo);
      exp_q.push_back(p);
    end
    step();
    cmp_trig = 1'b0;
  endtask

  task automatic period(input int hi, input int lo, input bit push);
    charge_phase(hi, 1);
    dis_phase(hi, lo, push);
  endtask

  task automatic chk_pins(input string tag, input logic r, input logic d, input logic o);
    chk({tag, "_ic_rst_n"}, ic_rst_n, r);
    chk({tag, "_dis_en"},   dis_en,   d);
    chk({tag, "_out_q"},    out_q,    o);
  endtask

  // scoreboard: every transfer must match the oldest expected pair
  always @(negedge clk) begin
    meas_pair_t p;
    if (!rst && meas_valid && meas_ready) begin
      chk("pair_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        chk("meas_hi", meas_hi, p.hi);
        chk("meas_lo", meas_lo, p.lo);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; cmp_trig = 1'b0; cmp_thresh = 1'b0; meas_ready = 1'b1;
    repeat (3) step();
    chk_pins("reset", 1'b0, 1'b1, 1'b0);
    chk("reset_valid", meas_valid, 0);
    chk("reset_fault", fault, 0);
    chk("reset_ovr",   meas_ovr, 0);
    rst = 1'b0;
    step();

    // 1: enable, RST_HOLD for 4 cycles, then CHARGE
    en = 1'b1;
    step();
    chk_pins("hold1", 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    chk_pins("hold4", 1'b0, 1'b1, 1'b0);
    step();
    chk_pins("charge", 1'b1, 1'b0, 1'b1);

    // 2: 30/20 periods, first one suppressed
    charge_phase(30, 1);
    chk_pins("discharge", 1'b1, 1'b1, 1'b0);
    dis_phase(30, 20, 1'b0);
    chk("first_suppressed", meas_valid, 0);
    for (int i = 0; i < 3; i++) period(30, 20, 1'b1);
    chk("ovr_clear", meas_ovr, 0);

    // 3: back-pressure across two completions
    step();
    meas_ready = 1'b0;
    charge_phase(30, 2);
    dis_phase(30, 20, 1'b1);
    chk("held_valid", meas_valid, 1);
    period(25, 15, 1'b0);
    chk("held_valid2", meas_valid, 1);
    chk("held_hi", meas_hi, 30);
    chk("held_lo", meas_lo, 20);
    chk("ovr_set", meas_ovr, 1);
    meas_ready = 1'b1;
    step();
    chk("valid_drop", meas_valid, 0);
    chk("q_drained", exp_q.size(), 0);

    // 4: timeout in CHARGE (now in cycle 2)
    repeat (98) step();
    chk("pre_tmo_out_q", out_q, 1);
    chk("pre_tmo_fault", fault, 0);
    step();
    chk("fault_set", fault, 1);
    chk_pins("fault", 1'b0, 1'b1, 1'b0);
    step();
    chk("fault_sticky", fault, 1);
    en = 1'b0;
    step();
    chk("fault_clr", fault, 0);
    chk_pins("idle", 1'b0, 1'b1, 1'b0);

    // 5: both comparators in CHARGE, then async reset mid-DISCHARGE
    en = 1'b1;
    repeat (5) step();
    chk_pins("charge5", 1'b1, 1'b0, 1'b1);
    cmp_trig = 1'b1; cmp_thresh = 1'b1;
    step();
    cmp_trig = 1'b0; cmp_thresh = 1'b0;
    chk_pins("both_cmp", 1'b1, 1'b1, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk_pins("async_rst", 1'b0, 1'b1, 1'b0);
    chk("async_hi",  meas_hi, 0);
    chk("async_lo",  meas_lo, 0);
    chk("async_ovr", meas_ovr, 0);
    chk("async_vld", meas_valid, 0);
    rst = 1'b0;

    // 6: en drop in DISCHARGE re-arms the suppression
    repeat (5) step();
    period(30, 20, 1'b0);
    period(30, 20, 1'b1);
    charge_phase(30, 1);
    repeat (5) step();
    en = 1'b0;
    step();
    chk_pins("en_drop", 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    repeat (5) step();
    chk_pins("reenable", 1'b1, 1'b0, 1'b1);
    period(30, 20, 1'b0);
    chk("resuppressed", meas_valid, 0);
    period(12, 7, 1'b1);
    step();
    chk("q_final", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
